// File: rtl/srt4_pkg.sv
// srt4_pkg: shared state encoding, response error codes and WAIT timeout limit for srt4_seq.
package srt4_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, LOAD_DIV, WAIT, RESP} state_t;
  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_DZ  = 2'b01;
  localparam logic [1:0] ERR_OVF = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;
  localparam logic [7:0] SRT4_SEQ_TIMEOUT = 8'd255;
endpackage

// File: rtl/srt4_seq_capture.sv
// srt4_seq_capture: one-byte divider outbus history plus quotient/remainder result registers.
module srt4_seq_capture (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] div_outbus,
  input  logic       cap,
  input  logic       ld,
  input  logic [7:0] ld_quot,
  input  logic [7:0] ld_rem,
  output logic [7:0] quot,
  output logic [7:0] rem
);
  logic [7:0] hist_q, hist_d, quot_q, quot_d, rem_q, rem_d;
  always_comb begin
    hist_d = div_outbus;
    quot_d = ld ? ld_quot : cap ? hist_q : quot_q;
    rem_d  = ld ? ld_rem : cap ? div_outbus : rem_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 8'h00;
      quot_q <= 8'h00;
      rem_q  <= 8'h00;
    end else begin
      hist_q <= hist_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
    end
  end
  assign quot = quot_q;
  assign rem  = rem_q;
endmodule

// File: rtl/srt4_seq.sv
// srt4_seq: sequencer feeding an external srt4 divider over a byte bus and returning quotient/remainder.
// Define SRT4_SEQ_TIMEOUT_EN to abandon a WAIT that sees no div_end within SRT4_SEQ_TIMEOUT cycles.
module srt4_seq
  import srt4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_dividend,
  input  logic [7:0]  req_divisor,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_quotient,
  output logic [7:0]  rsp_remainder,
  output logic [1:0]  rsp_err,
  output logic        div_begin,
  output logic [7:0]  div_inbus,
  input  logic [7:0]  div_outbus,
  input  logic        div_end
);
  state_t      state_q, state_d;
  logic [15:0] dividend_q, dividend_d;
  logic [7:0]  divisor_q, divisor_d, div_inbus_q, div_inbus_d, ld_quot, ld_rem;
  logic [1:0]  err_q, err_d;
  logic        req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, div_begin_q, div_begin_d, cap, ld;
`ifdef SRT4_SEQ_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    err_d      = err_q;
    cap        = 1'b0;
    ld         = 1'b0;
    ld_quot    = 8'h00;
    ld_rem     = 8'h00;
`ifdef SRT4_SEQ_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        dividend_d = req_dividend;
        divisor_d  = req_divisor;
        if (req_divisor == 8'h00) begin
          state_d = RESP;
          ld      = 1'b1;
          ld_quot = 8'hFF;
          ld_rem  = req_dividend[7:0];
          err_d   = ERR_DZ;
        end else if (req_dividend[15:8] >= req_divisor) begin
          state_d = RESP;
          ld      = 1'b1;
          ld_quot = 8'hFF;
          err_d   = ERR_OVF;
        end else state_d = LOAD_HI;
      end
      LOAD_HI: state_d = LOAD_LO;
      LOAD_LO: state_d = LOAD_DIV;
      LOAD_DIV: begin
        state_d = WAIT;
`ifdef SRT4_SEQ_TIMEOUT_EN
        cnt_d   = 8'h00;
`endif
      end
      WAIT: if (div_end) begin
        cap     = 1'b1;
        err_d   = ERR_OK;
        state_d = RESP;
      end
`ifdef SRT4_SEQ_TIMEOUT_EN
      else begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == SRT4_SEQ_TIMEOUT) begin
          state_d = RESP;
          ld      = 1'b1;
          err_d   = ERR_TMO;
        end
      end
`endif
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state they describe.
    req_ready_d = state_d == IDLE;
    rsp_valid_d = state_d == RESP;
    div_begin_d = state_d == LOAD_HI;
    div_inbus_d = state_d == LOAD_HI  ? dividend_d[15:8] :
                  state_d == LOAD_LO  ? dividend_d[7:0]  :
                  state_d == LOAD_DIV ? divisor_d        : 8'h00;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dividend_q  <= 16'h0000;
      divisor_q   <= 8'h00;
      err_q       <= ERR_OK;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      div_begin_q <= 1'b0;
      div_inbus_q <= 8'h00;
`ifdef SRT4_SEQ_TIMEOUT_EN
      cnt_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      div_begin_q <= div_begin_d;
      div_inbus_q <= div_inbus_d;
`ifdef SRT4_SEQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end
  srt4_seq_capture u_capture (
    .clk        (clk),
    .rst        (rst),
    .div_outbus (div_outbus),
    .cap        (cap),
    .ld         (ld),
    .ld_quot    (ld_quot),
    .ld_rem     (ld_rem),
    .quot       (rsp_quotient),
    .rem        (rsp_remainder)
  );
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = err_q;
  assign div_begin = div_begin_q;
  assign div_inbus = div_inbus_q;
endmodule

// File: tb/tb_srt4_seq.sv
// tb_srt4_seq: scoreboard bench for srt4_seq with a behavioural byte-bus divider model.
module tb_srt4_seq;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, rsp_ready = 1'b0, div_end = 1'b0;
  logic [15:0] req_dividend = 16'h0000;
  logic [7:0]  req_divisor = 8'h00, div_outbus = 8'h00;
  logic        req_ready, rsp_valid, div_begin;
  logic [7:0]  rsp_quotient, rsp_remainder, div_inbus;
  logic [1:0]  rsp_err;
  typedef struct packed {logic [7:0] q; logic [7:0] r; logic [1:0] e;} rsp_t;
  rsp_t exp_q[$];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  srt4_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_err(rsp_err), .div_begin(div_begin), .div_inbus(div_inbus),
    .div_outbus(div_outbus), .div_end(div_end)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  // One request end to end: drive, emulate the divider, score the response, then hold and release it.
  task automatic op(input logic [15:0] dd, input logic [7:0] dv, input int delay, input bit no_end, input int hold);
    rsp_t e;
    int mph = 0, nbeg = 0, endc = -1, divc = -1, cyc;
    logic [7:0] hi = 0, lo = 0, dvr = 0, mq = 0, mr = 0;
    bit seen = 0, skip;
    skip = dv == 8'h00 || dd[15:8] >= dv;
    if (dv == 8'h00) e = '{8'hFF, dd[7:0], 2'b01};
    else if (dd[15:8] >= dv) e = '{8'hFF, 8'h00, 2'b10};
    else if (no_end) e = '{8'h00, 8'h00, 2'b11};
    else e = '{8'(dd / 16'(dv)), 8'(dd % 16'(dv)), 2'b00};
    exp_q.push_back(e);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_dividend = dd; req_divisor = dv;
    @(negedge clk);
    req_valid = 1'b0;
    for (cyc = 0; cyc < 600; cyc++) begin
      if (rsp_valid) begin seen = 1; break; end
      div_end = 1'b0;
      div_outbus = 8'($urandom);
      if (div_begin) begin nbeg++; hi = div_inbus; mph = 1; end
      else if (mph == 1) begin lo = div_inbus; mph = 2; end
      else if (mph == 2) begin
        dvr = div_inbus; mq = 8'({hi, lo} / 16'(dvr)); mr = 8'({hi, lo} % 16'(dvr));
        mph = 3; divc = cyc;
      end else if (mph == 3) begin
        if (cyc == divc + 1) begin
          check("wait_begin", div_begin, 0);
          check("wait_inbus", div_inbus, 0);
        end
        if (!no_end) begin
          if (delay > 0) delay--;
          else begin div_outbus = mq; mph = 4; end
        end
      end else if (mph == 4) begin div_outbus = mr; div_end = 1'b1; endc = cyc; mph = 5; end
      @(negedge clk);
    end
    div_end = 1'b0;
    check("rsp_seen", seen, 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else check("queue_empty", 1, 0);
    if (skip) begin
      check("skip_begin", nbeg, 0);
      check("skip_latency", cyc, 0);
    end else begin
      check("begin_count", nbeg, 1);
      check("inbus_hi", hi, dd[15:8]);
      check("inbus_lo", lo, dd[7:0]);
      check("inbus_div", dvr, dv);
`ifdef SRT4_SEQ_TIMEOUT_EN
      if (no_end) check("tmo_wait_cycles", cyc - divc - 1, 255);
`endif
      if (!no_end) check("end_latency", cyc, endc + 1);
    end
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      if (h == hold) rsp_ready = 1'b1;
      check("rsp_valid", rsp_valid, 1);
      check("req_ready_busy", req_ready, 0);
      check("rsp_quotient", rsp_quotient, e.q);
      check("rsp_remainder", rsp_remainder, e.r);
      check("rsp_err", rsp_err, e.e);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_dropped", rsp_valid, 0);
    check("back_idle", req_ready, 1);
  endtask
  initial begin
    int rv;
    logic [7:0] dv, hi;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_quotient", rsp_quotient, 0);
    check("rst_remainder", rsp_remainder, 0);
    check("rst_err", rsp_err, 0);
    check("rst_div_begin", div_begin, 0);
    check("rst_div_inbus", div_inbus, 0);
    rst = 1'b0;
    @(negedge clk);
    op(16'h0064, 8'h07, 0, 0, 1);
    op(16'h0012, 8'h00, 0, 0, 1);
    op(16'h0A00, 8'h05, 0, 0, 1);
    op(16'h0B37, 8'h21, 3, 0, 10);
    op(16'h04FF, 8'h05, 1, 0, 1);
    op(16'h0500, 8'h05, 0, 0, 1);
    op(16'hFFFF, 8'hFF, 0, 0, 1);
    op(16'hFEFF, 8'hFF, 2, 0, 1);
    for (int i = 0; i < 6; i++) begin
      dv = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, int'(dv) - 1));
      op({hi, 8'($urandom)}, dv, $urandom_range(0, 4), 0, 2);
    end
    // Abandon an operation in WAIT, then offer a spurious div_end while idle.
    check("pre_rst_ready", req_ready, 1);
    req_valid = 1'b1; req_dividend = 16'h0050; req_divisor = 8'h03;
    @(negedge clk);
    req_valid = 1'b0;
    rv = 0;
`ifdef SRT4_SEQ_TIMEOUT_EN
    repeat (20) begin if (rsp_valid) rv++; @(negedge clk); end
`else
    repeat (300) begin if (rsp_valid) rv++; @(negedge clk); end
`endif
    check("wait_no_rsp", rv, 0);
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_div_inbus", div_inbus, 0);
    @(negedge clk);
    rst = 1'b0; div_end = 1'b1; div_outbus = 8'hAA;
    @(negedge clk);
    div_end = 1'b0; div_outbus = 8'h00;
    rv = 0;
    repeat (5) begin if (rsp_valid) rv++; @(negedge clk); end
    check("spurious_no_rsp", rv, 0);
    op(16'h00FF, 8'h10, 2, 0, 1);
`ifdef SRT4_SEQ_TIMEOUT_EN
    op(16'h0100, 8'h09, 0, 1, 1);
    op(16'h0123, 8'h0A, 1, 0, 1);
`endif
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
